// File: rtl/id_buffer_ctrl.sv
// Pointer and occupancy controller for the two-bank (a/b) ID1->ID2 instruction buffer.
// Program order alternates between the banks; up to two pushes and two pops per cycle.
module id_buffer_ctrl #(
  parameter int NUM   = 16,
  parameter int OCC_W = $clog2(2*NUM)+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  output logic             in_ready,
  output logic             wr_swap,
  output logic [NUM-1:0]   a_wr_onehot,
  output logic [NUM-1:0]   b_wr_onehot,
  output logic [NUM-1:0]   a_tail,
  output logic [NUM-1:0]   b_tail,
  output logic [1:0]       out_valid,
  output logic             out_first_b,
  input  logic [1:0]       out_pop,
  output logic [OCC_W-1:0] occ
);

  logic [NUM-1:0]   r_a_head, r_b_head, r_a_tail, r_b_tail;
  logic             r_wr_bank, r_rd_bank;
  logic [OCC_W-1:0] r_occ;

  logic [1:0] w_push_n, w_pop_req, w_pop_n;
  logic       w_a_we, w_b_we, w_a_pop, w_b_pop;

  function automatic logic [NUM-1:0] rotl(input logic [NUM-1:0] x);
    return {x[NUM-2:0], x[NUM-1]};
  endfunction

  // Reset and flush both suppress the push, so no write enable leaks into the banks.
  always_comb begin
    in_ready  = (r_occ <= OCC_W'(2*NUM-2));
    w_push_n  = 2'd0;
    if (in_ready && !flush && !rst)
      w_push_n = (in_valid == 2'b11) ? 2'd2 : (in_valid == 2'b01) ? 2'd1 : 2'd0;
    w_pop_req = (out_pop == 2'b11) ? 2'd2 : (out_pop == 2'b01) ? 2'd1 : 2'd0;
    w_pop_n   = (r_occ < OCC_W'(w_pop_req)) ? r_occ[1:0] : w_pop_req;
    w_a_we    = (w_push_n == 2'd2) || ((w_push_n == 2'd1) && !r_wr_bank);
    w_b_we    = (w_push_n == 2'd2) || ((w_push_n == 2'd1) &&  r_wr_bank);
    w_a_pop   = (w_pop_n == 2'd2) || ((w_pop_n == 2'd1) && !r_rd_bank);
    w_b_pop   = (w_pop_n == 2'd2) || ((w_pop_n == 2'd1) &&  r_rd_bank);
  end

  assign wr_swap     = r_wr_bank;
  assign a_wr_onehot = w_a_we ? r_a_head : '0;
  assign b_wr_onehot = w_b_we ? r_b_head : '0;
  assign a_tail      = r_a_tail;
  assign b_tail      = r_b_tail;
  assign out_first_b = r_rd_bank;
  assign occ         = r_occ;
  assign out_valid   = (r_occ == '0) ? 2'b00 : (r_occ == OCC_W'(1)) ? 2'b01 : 2'b11;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_a_head  <= NUM'(1);
      r_b_head  <= NUM'(1);
      r_a_tail  <= NUM'(1);
      r_b_tail  <= NUM'(1);
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_occ     <= '0;
    end else begin
      if (w_a_we)  r_a_head <= rotl(r_a_head);
      if (w_b_we)  r_b_head <= rotl(r_b_head);
      if (w_a_pop) r_a_tail <= rotl(r_a_tail);
      if (w_b_pop) r_b_tail <= rotl(r_b_tail);
      if (w_push_n[0]) r_wr_bank <= ~r_wr_bank;
      if (w_pop_n[0])  r_rd_bank <= ~r_rd_bank;
      r_occ <= r_occ + OCC_W'(w_push_n) - OCC_W'(w_pop_n);
    end
  end

endmodule

// File: tb/tb_id_buffer_ctrl.sv
// Self-checking bench: a sequence-number model (entry k lives in bank k%2, slot (k/2)%NUM)
// is compared against the controller every cycle, with literal checks pinning the model.
module tb_id_buffer_ctrl;
  localparam int NUM   = 16;
  localparam int OCC_W = $clog2(2*NUM)+1;

  logic             clk = 1'b0;
  logic             rst, flush, in_ready, wr_swap, out_first_b;
  logic [1:0]       in_valid, out_pop, out_valid;
  logic [NUM-1:0]   a_wr_onehot, b_wr_onehot, a_tail, b_tail;
  logic [OCC_W-1:0] occ;

  int nVectors = 0;
  int nFail    = 0;
  int mPushed  = 0;
  int mPopped  = 0;
  bit chkEn    = 1'b0;

  id_buffer_ctrl #(.NUM(NUM), .OCC_W(OCC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .wr_swap(wr_swap), .a_wr_onehot(a_wr_onehot), .b_wr_onehot(b_wr_onehot),
    .a_tail(a_tail), .b_tail(b_tail), .out_valid(out_valid), .out_first_b(out_first_b),
    .out_pop(out_pop), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pushCount(input int held, input logic [1:0] iv, input logic fl, input logic rs);
    if (rs || fl || held > 2*NUM-2) return 0;
    return (iv == 2'b11) ? 2 : (iv == 2'b01) ? 1 : 0;
  endfunction

  function automatic int popCount(input int held, input logic [1:0] op);
    int req;
    req = (op == 2'b11) ? 2 : (op == 2'b01) ? 1 : 0;
    return (req < held) ? req : held;
  endfunction

  // Model advances on the same edge as the DUT, using the inputs held over that edge.
  always @(posedge clk) begin
    int held, n, p;
    held = mPushed - mPopped;
    n = pushCount(held, in_valid, flush, rst);
    p = popCount(held, out_pop);
    if (rst || flush) begin
      mPushed = 0;
      mPopped = 0;
    end else begin
      mPushed = mPushed + n;
      mPopped = mPopped + p;
    end
  end

  always @(negedge clk) begin
    int held, n;
    logic [31:0] expA, expB, expValid;
    if (chkEn) begin
      held = mPushed - mPopped;
      n    = pushCount(held, in_valid, flush, rst);
      expA = '0;
      expB = '0;
      for (int j = 0; j < n; j++) begin
        if ((mPushed + j) % 2 == 0) expA = 32'd1 << (((mPushed + j) / 2) % NUM);
        else                        expB = 32'd1 << (((mPushed + j) / 2) % NUM);
      end
      expValid = (held == 0) ? 32'd0 : (held == 1) ? 32'd1 : 32'd3;
      checkOutput("occ",         32'(occ),         32'(held));
      checkOutput("in_ready",    32'(in_ready),    32'(held <= 2*NUM-2));
      checkOutput("out_valid",   32'(out_valid),   expValid);
      checkOutput("out_first_b", 32'(out_first_b), 32'(mPopped % 2));
      checkOutput("wr_swap",     32'(wr_swap),     32'(mPushed % 2));
      checkOutput("a_tail",      32'(a_tail),      32'd1 << (((mPopped + 1) / 2) % NUM));
      checkOutput("b_tail",      32'(b_tail),      32'd1 << ((mPopped / 2) % NUM));
      checkOutput("a_wr_onehot", 32'(a_wr_onehot), expA);
      checkOutput("b_wr_onehot", 32'(b_wr_onehot), expB);
      checkOutput("occ_bound",   32'(occ <= OCC_W'(2*NUM)), 32'd1);
    end
  end

  // Drive one cycle of inputs just after the edge, then return mid-cycle for literal checks.
  task automatic applyStimulus(input logic [1:0] iv, input logic [1:0] op, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    in_valid = iv;
    out_pop  = op;
    flush    = fl;
    rst      = rs;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    in_valid = 2'b00;
    out_pop  = 2'b00;
    flush    = 1'b0;
    rst      = 1'b1;
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
    chkEn = 1'b1;

    // Reset state and a dual push from empty
    idle();
    checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_occ",       32'(occ),       32'd0);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
    checkOutput("t1_a_wr",   32'(a_wr_onehot), 32'h0001);
    checkOutput("t1_b_wr",   32'(b_wr_onehot), 32'h0001);
    checkOutput("t1_swap",   32'(wr_swap),     32'd0);
    idle();
    checkOutput("t1_occ",    32'(occ),         32'd2);
    checkOutput("t1_valid",  32'(out_valid),   32'd3);
    checkOutput("t1_firstb", 32'(out_first_b), 32'd0);

    // Single pushes alternate a,b,a; one pop leaves the oldest in bank b
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    checkOutput("t2_w0_a", 32'(a_wr_onehot), 32'h0001);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    checkOutput("t2_w1_b", 32'(b_wr_onehot), 32'h0001);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    checkOutput("t2_w2_a", 32'(a_wr_onehot), 32'h0002);
    applyStimulus(2'b10, 2'b01, 1'b0, 1'b0);
    checkOutput("t2_10_ignored", 32'(a_wr_onehot | b_wr_onehot), 32'd0);
    idle();
    checkOutput("t2_firstb", 32'(out_first_b), 32'd1);
    checkOutput("t2_b_tail", 32'(b_tail),      32'h0001);
    checkOutput("t2_a_tail", 32'(a_tail),      32'h0002);
    checkOutput("t2_occ",    32'(occ),         32'd2);

    // Fill to capacity, push while full, then drain two and confirm the heads wrapped
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < NUM; i++) applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
    idle();
    checkOutput("t3_occ",   32'(occ),      32'd32);
    checkOutput("t3_ready", 32'(in_ready), 32'd0);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
    checkOutput("t3_full_wr", 32'(a_wr_onehot | b_wr_onehot), 32'd0);
    applyStimulus(2'b00, 2'b11, 1'b0, 1'b0);
    checkOutput("t3_occ_held", 32'(occ), 32'd32);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
    checkOutput("t3_wrap_a", 32'(a_wr_onehot), 32'h0001);

    // Simultaneous dual push and dual pop at occ=30 across the head wrap
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < NUM-1; i++) applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1'b0, 1'b0);
    checkOutput("t4_a_wr", 32'(a_wr_onehot), 32'h8000);
    idle();
    checkOutput("t4_occ",    32'(occ),    32'd30);
    checkOutput("t4_a_tail", 32'(a_tail), 32'h0002);
    checkOutput("t4_b_tail", 32'(b_tail), 32'h0002);
    applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
    checkOutput("t4_b_wr", 32'(b_wr_onehot), 32'h0001);

    // Excess pop on a single entry, then pop on empty
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    idle();
    checkOutput("t5_valid", 32'(out_valid), 32'd1);
    applyStimulus(2'b00, 2'b11, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b11, 1'b0, 1'b0);
    checkOutput("t5_occ",    32'(occ),         32'd0);
    checkOutput("t5_a_tail", 32'(a_tail),      32'h0002);
    checkOutput("t5_b_tail", 32'(b_tail),      32'h0001);
    checkOutput("t5_firstb", 32'(out_first_b), 32'd1);

    // Flush, then reset, colliding with push and pop
    for (int k = 0; k < 2; k++) begin
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b01, 2'b11, 1'b0, 1'b0);
      applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b11, 2'b11, k == 0, k == 1);
      checkOutput("t6_wr", 32'(a_wr_onehot | b_wr_onehot), 32'd0);
      idle();
      checkOutput("t6_occ",    32'(occ),       32'd0);
      checkOutput("t6_valid",  32'(out_valid), 32'd0);
      checkOutput("t6_tails",  32'(a_tail | b_tail), 32'h0001);
      applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
      checkOutput("t6_heads",  32'(a_wr_onehot & b_wr_onehot), 32'h0001);
    end

    // Mixed traffic checked by the model only
    for (int i = 0; i < 60; i++)
      applyStimulus(2'(i % 4 == 2 ? 1 : i % 3 == 0 ? 3 : 0), (i % 5 < 2) ? 2'b11 : 2'b01, 1'b0, 1'b0);
    idle();

    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
